// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo_pkg
// Brief  : Shared defaults and the status-flag bundle for sync_fifo_flags.
// Rev    : 1.0  initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_AF_MARGIN  = 4;
    localparam int DEF_AE_THRESH  = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo_ram
// Brief  : DEPTH x DATA_WIDTH simple dual-port storage for sync_fifo_flags.
//          SYNC_FIFO_FWFT_EN selects a combinational head read instead of
//          the registered read port.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    // Storage is deliberately not reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic w_unused_ok;

    assign o_rd_data   = r_mem[i_rd_addr];
    assign w_unused_ok = &{1'b0, i_rd_en, resetn};
`else
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Read-before-write: a pop at full sees the old word even when the
    // concurrent write targets the same slot.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo_flags
// Brief  : Single-clock FIFO with occupancy count, almost-full/empty
//          thresholds and sticky overflow/underflow flags. Define
//          SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int DEPTH       = DEF_DEPTH,
    parameter  int AF_THRESH   = DEPTH - DEF_AF_MARGIN,
    parameter  int AE_THRESH   = DEF_AE_THRESH,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [COUNT_WIDTH-1:0] c_depth     = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] c_af_thresh = COUNT_WIDTH'(AF_THRESH);
    localparam logic [COUNT_WIDTH-1:0] c_ae_thresh = COUNT_WIDTH'(AE_THRESH);
    localparam fifo_status_t c_status_reset = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0,
        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
    };

    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    fifo_status_t           r_status;
    fifo_status_t           w_status_nxt;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic [DATA_WIDTH-1:0]  w_ram_rd_data;

    // A read at full frees a slot, so the simultaneous write is still taken.
    assign w_rd_acc    = rd_en && !r_status.empty;
    assign w_wr_acc    = wr_en && (!r_status.full || w_rd_acc);
    assign w_count_nxt = r_count + COUNT_WIDTH'(w_wr_acc) - COUNT_WIDTH'(w_rd_acc);

    always_comb begin
        w_status_nxt              = c_status_reset;
        w_status_nxt.full         = (w_count_nxt == c_depth);
        w_status_nxt.empty        = (w_count_nxt == '0);
        w_status_nxt.almost_full  = (w_count_nxt >= c_af_thresh);
        w_status_nxt.almost_empty = (w_count_nxt <= c_ae_thresh);
        // A fresh error in the clearing cycle wins over clr_err.
        w_status_nxt.overflow     = (wr_en && !w_wr_acc) || (r_status.overflow && !clr_err);
        w_status_nxt.underflow    = (rd_en && !w_rd_acc) || (r_status.underflow && !clr_err);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= c_status_reset;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count  <= w_count_nxt;
            r_status <= w_status_nxt;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clock     (clock),
        .resetn    (resetn),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = r_status.empty ? '0 : w_ram_rd_data;
`else
    assign data_out = w_ram_rd_data;
`endif

    assign count        = r_count;
    assign full         = r_status.full;
    assign empty        = r_status.empty;
    assign almost_full  = r_status.almost_full;
    assign almost_empty = r_status.almost_empty;
    assign overflow     = r_status.overflow;
    assign underflow    = r_status.underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// Bench for sync_fifo_flags: a 1024-deep and a 16-deep instance share one
// stimulus stream and are both compared against queue-based reference models.
module tb_sync_fifo_flags;
    import sync_fifo_pkg::*;

    localparam int DW        = 32;
    localparam int BIG_DEPTH = 1024;
    localparam int BIG_AF    = BIG_DEPTH - 4;
    localparam int BIG_AE    = 4;
    localparam int SM_DEPTH  = 16;
    localparam int SM_AF     = 12;
    localparam int SM_AE     = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          resetn, wr_en, rd_en, clr_err;
    logic [DW-1:0] data_in;

    logic [DW-1:0] b_dout, s_dout;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [10:0]   b_count;
    logic [4:0]    s_count;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(BIG_DEPTH), .AF_THRESH(BIG_AF), .AE_THRESH(BIG_AE)) u_big (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf));

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(SM_DEPTH), .AF_THRESH(SM_AF), .AE_THRESH(SM_AE)) u_small (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (index 0 = big, 1 = small) ----------------
    logic [DW-1:0] q_big[$];
    logic [DW-1:0] q_sm[$];
    logic [DW-1:0] m_dout[2];
    bit            m_ovf[2];
    bit            m_unf[2];

    function automatic int m_size(input int i);
        return (i == 0) ? q_big.size() : q_sm.size();
    endfunction
    function automatic int m_depth(input int i);
        return (i == 0) ? BIG_DEPTH : SM_DEPTH;
    endfunction
    function automatic logic [DW-1:0] m_head(input int i);
        if (m_size(i) == 0) return '0;
        return (i == 0) ? q_big[0] : q_sm[0];
    endfunction

    task automatic model_step(input int i, input bit rst_n, input bit wr, input bit rd,
                              input bit clr, input logic [DW-1:0] din);
        int  n;
        bit  rd_ok, wr_ok;
        if (!rst_n) begin
            if (i == 0) q_big.delete(); else q_sm.delete();
            m_dout[i] = '0;
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
            return;
        end
        n     = m_size(i);
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < m_depth(i)) || rd_ok);
        if (rd_ok) m_dout[i] = (i == 0) ? q_big.pop_front() : q_sm.pop_front();
        if (wr_ok) begin
            if (i == 0) q_big.push_back(din); else q_sm.push_back(din);
        end
        if (wr && !wr_ok) m_ovf[i] = 1'b1; else if (clr) m_ovf[i] = 1'b0;
        if (rd && !rd_ok) m_unf[i] = 1'b1; else if (clr) m_unf[i] = 1'b0;
    endtask

    function automatic fifo_status_t m_status(input int i);
        fifo_status_t s;
        int n = m_size(i);
        s.full         = (n == m_depth(i));
        s.empty        = (n == 0);
        s.almost_full  = (n >= ((i == 0) ? BIG_AF : SM_AF));
        s.almost_empty = (n <= ((i == 0) ? BIG_AE : SM_AE));
        s.overflow     = m_ovf[i];
        s.underflow    = m_unf[i];
        return s;
    endfunction

    function automatic logic [DW-1:0] m_exp_dout(input int i);
`ifdef SYNC_FIFO_FWFT_EN
        return m_head(i);
`else
        return m_dout[i];
`endif
    endfunction

    task automatic check_model(input int i);
        fifo_status_t act_s;
        logic [DW-1:0] act_d;
        int act_c;
        string tag;
        if (i == 0) begin
            act_s = {b_full, b_empty, b_af, b_ae, b_ovf, b_unf};
            act_d = b_dout; act_c = int'(b_count); tag = "big";
        end else begin
            act_s = {s_full, s_empty, s_af, s_ae, s_ovf, s_unf};
            act_d = s_dout; act_c = int'(s_count); tag = "small";
        end
        chk({tag, " status"}, 64'(act_s), 64'(m_status(i)));
        chk({tag, " count"}, 64'(act_c), 64'(m_size(i)));
        chk({tag, " data_out"}, 64'(act_d), 64'(m_exp_dout(i)));
    endtask

    // Drive after the falling edge, let the DUT sample on the rising edge,
    // then compare on the next falling edge.
    task automatic cycle(input bit rst_n, input bit wr, input bit rd, input bit clr,
                         input logic [DW-1:0] din);
        resetn = rst_n; wr_en = wr; rd_en = rd; clr_err = clr; data_in = din;
        @(posedge clock);
        model_step(0, rst_n, wr, rd, clr, din);
        model_step(1, rst_n, wr, rd, clr, din);
        @(negedge clock);
        check_model(0);
        check_model(1);
    endtask

    task automatic push(input logic [DW-1:0] d); cycle(1'b1, 1'b1, 1'b0, 1'b0, d);  endtask
    task automatic pop();                        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0); endtask
    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    typedef struct {
        bit            rst_n, wr, rd, clr;
        logic [DW-1:0] din;
        int            cnt;
        bit            empty, unf;
        logic [DW-1:0] dout_reg, dout_fwft;
    } vec_t;

    localparam logic [DW-1:0] A1 = 32'h1111_0001;
    localparam logic [DW-1:0] A2 = 32'h2222_0002;
    localparam logic [DW-1:0] A3 = 32'h3333_0003;

    initial begin
        vec_t          vecs[11];
        logic [DW-1:0] sent[$];
        logic [DW-1:0] x, held, w;
        int            pw[6], pr[6];

        resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;

        // Expectations are for the 16-deep instance.
        vecs[0]  = '{0, 0, 0, 0, '0, 0, 1, 0, '0, '0};
        vecs[1]  = '{1, 0, 1, 0, '0, 0, 1, 1, '0, '0};
        vecs[2]  = '{1, 1, 1, 0, A1, 1, 0, 1, '0, A1};
        vecs[3]  = '{1, 1, 0, 0, A2, 2, 0, 1, '0, A1};
        vecs[4]  = '{1, 0, 0, 1, '0, 2, 0, 0, '0, A1};
        vecs[5]  = '{1, 0, 1, 0, '0, 1, 0, 0, A1, A2};
        vecs[6]  = '{1, 1, 1, 0, A3, 1, 0, 0, A2, A3};
        vecs[7]  = '{1, 0, 1, 0, '0, 0, 1, 0, A3, '0};
        vecs[8]  = '{1, 0, 1, 0, '0, 0, 1, 1, A3, '0};
        vecs[9]  = '{1, 0, 1, 1, '0, 0, 1, 1, A3, '0};
        vecs[10] = '{1, 0, 0, 1, '0, 0, 1, 0, A3, '0};

        @(negedge clock);
        for (int k = 0; k < 11; k++) begin
            cycle(vecs[k].rst_n, vecs[k].wr, vecs[k].rd, vecs[k].clr, vecs[k].din);
            chk($sformatf("vec%0d count", k), 64'(s_count), 64'(vecs[k].cnt));
            chk($sformatf("vec%0d empty", k), 64'(s_empty), 64'(vecs[k].empty));
            chk($sformatf("vec%0d underflow", k), 64'(s_unf), 64'(vecs[k].unf));
`ifdef SYNC_FIFO_FWFT_EN
            chk($sformatf("vec%0d data_out", k), 64'(s_dout), 64'(vecs[k].dout_fwft));
`else
            chk($sformatf("vec%0d data_out", k), 64'(s_dout), 64'(vecs[k].dout_reg));
`endif
        end

        // Basic order: 24 in, 24 out.
        do_reset(1);
        for (int k = 0; k < 24; k++) push($urandom());
        chk("basic count 24", 64'(b_count), 64'd24);
        for (int k = 0; k < 24; k++) pop();
        chk("basic count 0", 64'(b_count), 64'd0);
        chk("basic empty", 64'(b_empty), 64'd1);
        chk("basic errors", 64'({b_ovf, b_unf}), 64'd0);

        // Thresholds on the 16-deep instance.
        do_reset(1);
        for (int k = 1; k <= 12; k++) begin
            push($urandom());
            if (k == 11) chk("af below thresh", 64'(s_af), 64'd0);
            if (k == 12) chk("af at thresh", 64'(s_af), 64'd1);
        end
        for (int k = 11; k >= 4; k--) begin
            pop();
            if (k == 5) chk("ae above thresh", 64'(s_ae), 64'd0);
            if (k == 4) chk("ae at thresh", 64'(s_ae), 64'd1);
        end

        // Overflow: 1030 pushes into 1024 entries.
        do_reset(1);
        sent.delete();
        for (int k = 1; k <= 1030; k++) begin
            w = $urandom();
            sent.push_back(w);
            push(w);
            if (k == 1023) chk("full before 1024", 64'(b_full), 64'd0);
            if (k == 1024) chk("full at 1024", 64'({b_full, b_ovf}), 64'b10);
            if (k == 1025) chk("overflow at 1025", 64'(b_ovf), 64'd1);
            if (k == 1030) chk("overflow sticky", 64'(b_ovf), 64'd1);
        end
        for (int k = 0; k < 1024; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("ovf drain head", 64'(b_dout), 64'(sent[k]));
            pop();
`else
            pop();
            chk("ovf drain word", 64'(b_dout), 64'(sent[k]));
`endif
        end
        chk("ovf drained empty", 64'(b_empty), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("clr_err clears ovf", 64'(b_ovf), 64'd0);

        // Simultaneous read and write at full.
        for (int k = 0; k < 1024; k++) push($urandom());
        x = 32'hCAFE_F00D;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, x);
        chk("rw at full count", 64'(b_count), 64'd1024);
        chk("rw at full no ovf", 64'({b_full, b_ovf}), 64'b10);
        for (int k = 0; k < 1024; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
            if (k == 1023) chk("rw at full last head", 64'(b_dout), 64'(x));
`endif
            pop();
        end
`ifndef SYNC_FIFO_FWFT_EN
        chk("rw at full last word", 64'(b_dout), 64'(x));
`endif

        // Underflow at empty, then write+read at empty.
`ifdef SYNC_FIFO_FWFT_EN
        held = '0;
`else
        held = x;
`endif
        for (int k = 0; k < 3; k++) begin
            pop();
            chk("underflow set", 64'({b_unf, b_count}), 64'({1'b1, 11'd0}));
            chk("underflow dout held", 64'(b_dout), 64'(held));
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h5A5A_1234);
        chk("wr+rd at empty count", 64'(b_count), 64'd1);
        chk("wr+rd at empty unf sticky", 64'(b_unf), 64'd1);

        // Reset mid-stream.
        for (int k = 0; k < 100; k++) push($urandom());
        do_reset(5);
        chk("midrst big status", 64'({b_full, b_empty, b_af, b_ae, b_ovf, b_unf}), 64'b010100);
        chk("midrst small status", 64'({s_full, s_empty, s_af, s_ae, s_ovf, s_unf}), 64'b010100);
        chk("midrst count", 64'(b_count), 64'd0);
        sent.delete();
        for (int k = 0; k < 8; k++) begin
            w = $urandom();
            sent.push_back(w);
            push(w);
        end
        chk("post-rst count 8", 64'(b_count), 64'd8);
`ifdef SYNC_FIFO_FWFT_EN
        chk("post-rst head visible", 64'(b_dout), 64'(sent[0]));
`else
        chk("post-rst dout idle", 64'(b_dout), 64'd0);
`endif
        for (int k = 0; k < 8; k++) begin
            pop();
`ifndef SYNC_FIFO_FWFT_EN
            chk("post-rst word", 64'(b_dout), 64'(sent[k]));
`endif
        end

        // Randomised traffic in phases of differing write/read bias.
        pw = '{80, 20, 50, 95, 5, 50};
        pr = '{20, 80, 50, 5, 95, 50};
        for (int ph = 0; ph < 6; ph++) begin
            for (int k = 0; k < 500; k++) begin
                cycle(($urandom_range(996) != 0),
                      ($urandom_range(99) < pw[ph]),
                      ($urandom_range(99) < pr[ph]),
                      ($urandom_range(31) == 0),
                      $urandom());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
